// File: rtl/cache_profiler_ctrl.sv
// rtl/cache_profiler_ctrl.sv - host command sequencer, snapshot bank and read streamer for the cache profiler
module cache_profiler_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] icache_request_cnt,
  input  logic [CNT_W-1:0] icache_hit_cnt,
  input  logic [CNT_W-1:0] icache_miss_cnt,
  input  logic [CNT_W-1:0] dcache_request_cnt,
  input  logic [CNT_W-1:0] dcache_hit_cnt,
  input  logic [CNT_W-1:0] dcache_miss_cnt,
  output logic             profiler_enable,
  output logic             running,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] rd_data,
  output logic [2:0]       rd_index,
  output logic             rd_last
);

  typedef enum logic [1:0] {IDLE, RUN, CLR, STREAM} state_t;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  state_t           state;
  logic             from_run;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_next;
  logic [CNT_W-1:0] snap [7];
  logic [CNT_W-1:0] live [7];
  logic [CNT_W-1:0] next_word;
  logic             cmd_fire;
  logic             rd_fire;

  assign cmd_ready = (state == IDLE) || (state == RUN);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rd_fire   = rd_valid & rd_ready;

  // Word 6 captures the count including the capture edge itself, so a run of
  // N enabled cycles reports exactly N.
  always_comb begin
    cyc_next = cyc_cnt;
    if (profiler_enable && (cyc_cnt != {CNT_W{1'b1}}))
      cyc_next = cyc_cnt + 1'b1;
    live[0] = icache_request_cnt;
    live[1] = icache_hit_cnt;
    live[2] = icache_miss_cnt;
    live[3] = dcache_request_cnt;
    live[4] = dcache_hit_cnt;
    live[5] = dcache_miss_cnt;
    live[6] = cyc_next;
  end

  always_comb begin
    next_word = snap[6];
    case (rd_index)
      3'd0:    next_word = snap[1];
      3'd1:    next_word = snap[2];
      3'd2:    next_word = snap[3];
      3'd3:    next_word = snap[4];
      3'd4:    next_word = snap[5];
      default: next_word = snap[6];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      from_run        <= 1'b0;
      cyc_cnt         <= '0;
      profiler_enable <= 1'b0;
      running         <= 1'b0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      rd_index        <= '0;
      rd_last         <= 1'b0;
      for (int i = 0; i < 7; i++) snap[i] <= '0;
    end else begin
      cyc_cnt <= cyc_next;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_START: begin
                state           <= RUN;
                profiler_enable <= 1'b1;
                running         <= 1'b1;
                cyc_cnt         <= '0;
              end
              OP_CLEAR: for (int i = 0; i < 7; i++) snap[i] <= '0;
              OP_READ: begin
                state    <= STREAM;
                from_run <= 1'b0;
                rd_valid <= 1'b1;
                rd_index <= '0;
                rd_last  <= 1'b0;
                rd_data  <= snap[0];
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_STOP: begin
                for (int i = 0; i < 7; i++) snap[i] <= live[i];
                state           <= IDLE;
                profiler_enable <= 1'b0;
                running         <= 1'b0;
              end
              OP_CLEAR: begin
                state           <= CLR;
                profiler_enable <= 1'b0;
                running         <= 1'b0;
                cyc_cnt         <= '0;
              end
              OP_READ: begin
                for (int i = 0; i < 7; i++) snap[i] <= live[i];
                state    <= STREAM;
                from_run <= 1'b1;
                rd_valid <= 1'b1;
                rd_index <= '0;
                rd_last  <= 1'b0;
                rd_data  <= live[0];
              end
              default: ;
            endcase
          end
        end
        CLR: begin
          state           <= RUN;
          profiler_enable <= 1'b1;
          running         <= 1'b1;
        end
        STREAM: begin
          if (rd_fire) begin
            if (rd_index == 3'd6) begin
              state    <= from_run ? RUN : IDLE;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              rd_index <= '0;
            end else begin
              rd_index <= rd_index + 3'd1;
              rd_data  <= next_word;
              rd_last  <= (rd_index == 3'd5);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_profiler_ctrl.sv
// tb/tb_cache_profiler_ctrl.sv - directed self-checking bench for cache_profiler_ctrl
module tb_cache_profiler_ctrl;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic [31:0] ic_req = '0, ic_hit = '0, ic_miss = '0;
  logic [31:0] dc_req = '0, dc_hit = '0, dc_miss = '0;
  logic        profiler_enable, running, rd_valid, rd_last;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic [2:0]  rd_index;

  int n_checks = 0;
  int n_fail = 0;
  int en_total = 0;
  logic [31:0] rd_words [7];

  typedef struct {
    logic [5:0][31:0] cnt;
    int               run_cycles;
    logic [31:0]      exp_cyc;
  } vec_t;

  cache_profiler_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .icache_request_cnt(ic_req), .icache_hit_cnt(ic_hit), .icache_miss_cnt(ic_miss),
    .dcache_request_cnt(dc_req), .dcache_hit_cnt(dc_hit), .dcache_miss_cnt(dc_miss),
    .profiler_enable(profiler_enable), .running(running), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_index(rd_index), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (profiler_enable) en_total <= en_total + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [5:0][31:0] c);
    ic_req = c[0]; ic_hit = c[1]; ic_miss = c[2];
    dc_req = c[3]; dc_hit = c[4]; dc_miss = c[5];
  endtask

  // Called just after a rising edge; the command is accepted on the next edge it is ready.
  task automatic send_cmd(input logic [1:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic read_stream(input bit exp_run, input bit toggle, input bit hold_cmd);
    int cyc = 0;
    int got = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [31:0] prev_d = '0;
    send_cmd(OP_READ);
    if (hold_cmd) begin
      cmd_valid = 1'b1;
      cmd_op = OP_STOP;
    end
    while (!done && cyc < 60) begin
      rd_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
      @(negedge clk);
      check("stream_rd_valid", rd_valid, 1);
      check("stream_rd_index", rd_index, got);
      check("stream_rd_last", rd_last, got == 6);
      if (prev_stall) check("stall_data_stable", rd_data, prev_d);
      if (hold_cmd) check("stream_cmd_ready_low", cmd_ready, 0);
      if (exp_run) check("stream_enable_high", profiler_enable, 1);
      if (rd_ready) begin
        rd_words[got] = rd_data;
        if (got == 6) begin
          done = 1;
          cmd_valid = 1'b0;
        end
        got++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        prev_d = rd_data;
      end
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) check("stream_timeout", 0, 1);
    rd_ready = 1'b0;
    cmd_valid = 1'b0;
    check("stream_end_rd_valid", rd_valid, 0);
  endtask

  vec_t vecs [3];
  logic [5:0][31:0] c;

  initial begin
    vecs[0].cnt = {32'd5, 32'd15, 32'd20, 32'd3, 32'd7, 32'd10};
    vecs[0].run_cycles = 100; vecs[0].exp_cyc = 32'd100;
    vecs[1].cnt = {32'hA5A5_5A5A, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFF};
    vecs[1].run_cycles = 1; vecs[1].exp_cyc = 32'd1;
    vecs[2].cnt = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[2].run_cycles = 7; vecs[2].exp_cyc = 32'd7;

    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_enable", profiler_enable, 0);
    check("rst_running", running, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_index", rd_index, 0);
    check("rst_rd_last", rd_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 3; v++) begin
      int base;
      set_inputs(vecs[v].cnt);
      base = en_total;
      send_cmd(OP_START);
      check($sformatf("vec%0d_running", v), running, 1);
      repeat (vecs[v].run_cycles - 1) @(posedge clk);
      #1 send_cmd(OP_STOP);
      check($sformatf("vec%0d_enable_cycles", v), en_total - base, vecs[v].run_cycles);
      check($sformatf("vec%0d_stopped", v), profiler_enable, 0);
      set_inputs(~vecs[v].cnt);
      read_stream(0, 0, 0);
      for (int i = 0; i < 6; i++)
        check($sformatf("vec%0d_word%0d", v, i), rd_words[i], vecs[v].cnt[i]);
      check($sformatf("vec%0d_word6", v), rd_words[6], vecs[v].exp_cyc);
    end

    send_cmd(OP_CLEAR);
    read_stream(0, 0, 0);
    for (int i = 0; i < 7; i++) check($sformatf("idle_clear_word%0d", i), rd_words[i], 0);

    c = {32'd66, 32'd55, 32'd44, 32'd33, 32'd22, 32'd11};
    set_inputs(c);
    send_cmd(OP_START);
    repeat (4) @(posedge clk);
    #1 send_cmd(OP_CLEAR);
    @(negedge clk);
    check("clr_enable_low", profiler_enable, 0);
    check("clr_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("clr_enable_back", profiler_enable, 1);
    check("clr_cmd_ready_back", cmd_ready, 1);
    repeat (19) @(posedge clk);
    #1 send_cmd(OP_STOP);
    read_stream(0, 0, 0);
    check("clr_run_word6", rd_words[6], 20);

    send_cmd(OP_START);
    repeat (9) @(posedge clk);
    #1 read_stream(1, 1, 1);
    for (int i = 0; i < 6; i++) check($sformatf("live_word%0d", i), rd_words[i], c[i]);
    check("live_word6", rd_words[6], 10);
    check("live_back_running", running, 1);
    check("live_back_enable", profiler_enable, 1);
    send_cmd(OP_STOP);
    read_stream(0, 0, 0);
    check("after_live_word6", rd_words[6], 30);

    begin
      int n = 0;
      send_cmd(OP_START);
      repeat (4) @(posedge clk);
      #1 send_cmd(OP_READ);
      rd_ready = 1'b1;
      @(negedge clk);
      while (rd_index != 3'd3 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_reached_idx3", rd_index, 3);
      rst_n = 1'b0;
      #1;
      check("rst_mid_rd_valid", rd_valid, 0);
      check("rst_mid_enable", profiler_enable, 0);
      check("rst_mid_running", running, 0);
      rd_ready = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      read_stream(0, 0, 0);
      for (int i = 0; i < 7; i++) check($sformatf("post_rst_word%0d", i), rd_words[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_profiler_ctrl.md
# cache_profiler_ctrl

Host-facing controller for the cache profiler counter block. It sequences the profiler's `enable` line through run, stop and clear commands. It captures the six cache counters plus an elapsed-cycle count into a snapshot bank, and streams the snapshot to the host as seven words over a valid/ready read channel. It sits between the host command path and the profiler, and is the only driver of the profiler's `enable`.

## Interface
- `CNT_W`, default 32: width of every counter, snapshot word and `rd_data`.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command valid.
- `cmd_op` in 2: command; 0 START, 1 STOP, 2 CLEAR, 3 READ.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `icache_request_cnt`, `icache_hit_cnt`, `icache_miss_cnt` in CNT_W each: live profiler icache counters.
- `dcache_request_cnt`, `dcache_hit_cnt`, `dcache_miss_cnt` in CNT_W each: live profiler dcache counters.
- `profiler_enable` out 1: registered enable to the profiler. Low clears the profiler's counters.
- `running` out 1: run flag; 1 while in RUN, or in STREAM entered from RUN.
- `rd_valid` out 1: read word valid.
- `rd_ready` in 1: host accepts the read word.
- `rd_data` out CNT_W: read word.
- `rd_index` out 3: word index 0..6.
- `rd_last` out 1: high with index 6.

## Operation
- States: IDLE, RUN, CLR, STREAM.
- `cmd_ready` = 1 in IDLE and RUN, 0 in CLR and STREAM. It is combinational from state.
- Snapshot word order:
  - 0 icache_request, 1 icache_hit, 2 icache_miss
  - 3 dcache_request, 4 dcache_hit, 5 dcache_miss
  - 6 cycle count
- Cycle counter: CNT_W bits.
  - Increments each cycle `profiler_enable` = 1.
  - Saturates at all-ones.
  - Zeroed on START accept (from IDLE) and on CLEAR accept (from RUN).
- START:
  - IDLE -> RUN; `profiler_enable` 1 from the next cycle.
  - In RUN: accepted, no effect.
- STOP:
  - In RUN: snapshot all six inputs plus the cycle counter on the accept edge, then RUN -> IDLE; `profiler_enable` 0 from the next cycle.
  - In IDLE: accepted, no effect; the snapshot is retained.
- CLEAR:
  - In RUN: RUN -> CLR; `profiler_enable` 0 for exactly one cycle; CLR -> RUN unconditionally; cycle counter zeroed.
  - In IDLE: all seven snapshot words zeroed; stays IDLE.
- READ:
  - In RUN: take a live snapshot on the accept edge; the profiler keeps running and `profiler_enable` stays 1.
  - In IDLE: the existing snapshot is used.
  - Either case: enter STREAM with `rd_index` = 0.
- STREAM:
  - Presents word `rd_index` with `rd_valid` = 1.
  - On `rd_valid & rd_ready`, the index increments.
  - On the handshake with index 6, returns to the originating state (IDLE or RUN) and `rd_valid` drops the next cycle.
  - The cycle counter keeps counting during STREAM while `profiler_enable` = 1.
- `cmd_valid` while `cmd_ready` = 0: ignored. The host must hold it until accepted.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - state IDLE, `cmd_ready` 1.
  - `profiler_enable` 0, `running` 0.
  - `rd_valid` 0, `rd_data` 0, `rd_index` 0, `rd_last` 0.
  - Cycle counter and all snapshot words 0.
- Reset during STREAM: the stream is aborted and `rd_valid` falls immediately.
- Command latency:
  - Accept on edge N; `profiler_enable` and `running` change after edge N.
  - Snapshot registers hold values sampled at edge N.
- STREAM registers:
  - `rd_data`, `rd_index` and `rd_last` are registered.
  - First `rd_valid` appears in the cycle after the READ accept.
  - While `rd_valid & !rd_ready`, `rd_data`, `rd_index` and `rd_last` hold stable.
- Throughput: one word per cycle with `rd_ready` held high, so 7 cycles per stream. The first command after the stream can be accepted in the cycle `rd_valid` falls.
- Profiler counter inputs are sampled as presented; the block applies no arithmetic to them.
- The snapshot is a single-edge capture, so all seven words are mutually consistent.

## Test plan
- Reset, START, 100 cycles, STOP, READ with `rd_ready` = 1:
  - `profiler_enable` high for exactly 100 cycles.
  - Seven words, indices 0..6, snapshot of the inputs at the STOP edge, word 6 = 100.
  - `rd_last` high only on index 6.
- Profiler inputs held at icache req/hit/miss = 10/7/3 and dcache req/hit/miss = 20/15/5, then STOP and READ:
  - words 0..6 = 10, 7, 3, 20, 15, 5, cycles.
- CLEAR in RUN:
  - `profiler_enable` low for exactly one cycle, then high.
  - `cmd_ready` = 0 for that cycle.
  - A following STOP/READ reports word 6 counted from the CLEAR.
- READ in RUN with `rd_ready` toggling 1,0,0,1,...:
  - `rd_data` stable during stalls.
  - `profiler_enable` stays 1 throughout.
  - Returns to RUN; `cmd_valid` during the stream is not accepted.
- `rst_n` asserted mid-stream at index 3:
  - `rd_valid`, `profiler_enable` and `running` go 0 immediately.
  - A READ after reset returns seven zero words.
- CLEAR in IDLE after a snapshot with nonzero values, then READ:
  - all seven words 0.
